// File: rtl/nvram_upload_server.sv
// nvram_upload_server: answers HPS NVRAM upload reads from the shared CMOS RAM
// read port (CPU has priority) and tracks NVRAM dirtiness, raising a one-shot
// save request once the CPU has been write-quiet for SAVE_FRAMES frames.
module nvram_upload_server #(
  parameter int          ADDR_W      = 10,
  parameter int          DATA_W      = 4,
  parameter int          NV_INDEX    = 4,
  parameter int          RAM_LAT     = 1,
  parameter int          SAVE_FRAMES = 120,
  parameter logic [3:0]  PAD         = 4'hF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  input  logic              cpu_busy,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              vblank,
  output logic              dirty,
  output logic              save_req
);

  localparam int CNT_W = $clog2(SAVE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ARB, READ, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, addr_next;
  logic              oob, oob_next;
  logic [1:0]        lat_cnt, lat_cnt_next;
  logic [7:0]        cap, cap_next;
  logic [7:0]        din_next;
  logic              wait_next;
  logic              rd_next;
  logic [ADDR_W-1:0] ram_addr_next;
  logic [7:0]        ram_byte;

  logic              nv_sel;
  logic              req;
  logic              oob_req;

  assign nv_sel  = (ioctl_index == 8'(NV_INDEX));
  assign req     = ioctl_rd & ioctl_upload & nv_sel;
  assign oob_req = |(ioctl_addr >> ADDR_W);

  // Widen the RAM word to the uploaded byte; narrow RAMs get the pad nibble on top.
  generate
    if (DATA_W == 4) begin : g_nibble
      assign ram_byte = {PAD, ram_q};
    end else begin : g_byte
      assign ram_byte = ram_q[7:0];
    end
  endgenerate

  // State and registered outputs of the upload read machine.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr       <= '0;
      oob        <= 1'b0;
      lat_cnt    <= 2'd0;
      cap        <= 8'h00;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      oob        <= oob_next;
      lat_cnt    <= lat_cnt_next;
      cap        <= cap_next;
      ioctl_din  <= din_next;
      ioctl_wait <= wait_next;
      ram_rd     <= rd_next;
      ram_addr   <= ram_addr_next;
    end
  end

  // Next-state and next-output decode. An out-of-range request passes through
  // ARB without touching the RAM so that ioctl_wait is seen high for one cycle.
  always_comb begin
    state_next    = state;
    addr_next     = addr;
    oob_next      = oob;
    lat_cnt_next  = lat_cnt;
    cap_next      = cap;
    din_next      = ioctl_din;
    wait_next     = ioctl_wait;
    rd_next       = 1'b0;
    ram_addr_next = ram_addr;
    case (state)
      IDLE: begin
        if (req) begin
          addr_next  = ioctl_addr[ADDR_W-1:0];
          oob_next   = oob_req;
          state_next = ARB;
        end
      end
      ARB: begin
        wait_next = 1'b1;
        if (oob) begin
          cap_next   = 8'hFF;
          state_next = DONE;
        end else if (!cpu_busy) begin
          rd_next       = 1'b1;
          ram_addr_next = addr;
          lat_cnt_next  = 2'd0;
          state_next    = READ;
        end
      end
      READ: begin
        if (lat_cnt == 2'(RAM_LAT - 1)) begin
          cap_next   = ram_byte;
          state_next = DONE;
        end else begin
          lat_cnt_next = lat_cnt + 2'd1;
        end
      end
      DONE: begin
        din_next   = cap;
        wait_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic             vblank_d;
  logic             upload_d;
  logic [CNT_W-1:0] frame_cnt;
  logic             vb_rise;
  logic             up_fall;

  assign vb_rise = vblank & ~vblank_d;
  assign up_fall = upload_d & ~ioctl_upload & nv_sel;

  // Dirty flag and write-quiet frame counter; a CPU write beats an upload end.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vblank_d  <= 1'b0;
      upload_d  <= 1'b0;
      frame_cnt <= '0;
      dirty     <= 1'b0;
      save_req  <= 1'b0;
    end else begin
      vblank_d <= vblank;
      upload_d <= ioctl_upload;
      save_req <= 1'b0;
      if (cpu_we) begin
        dirty     <= 1'b1;
        frame_cnt <= '0;
      end else if (up_fall) begin
        dirty     <= 1'b0;
        frame_cnt <= '0;
      end else if (dirty && vb_rise && (frame_cnt < CNT_W'(SAVE_FRAMES))) begin
        frame_cnt <= frame_cnt + 1'b1;
        if (frame_cnt == CNT_W'(SAVE_FRAMES - 1)) begin
          save_req <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_nvram_upload_server.sv
// Directed bench for nvram_upload_server: upload reads (plain, contended,
// out-of-range, wrong index), dirty/save timing and asynchronous reset.
module tb_nvram_upload_server;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_busy = 1'b0;
  logic        cpu_we = 1'b0;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [3:0]  ram_q;
  logic        vblank = 1'b0;
  logic        dirty;
  logic        save_req;

  int checks = 0;
  int errors = 0;
  int save_seen = 0;

  logic [3:0] mem [0:1023];

  // One-cycle-latency RAM: data for the address presented with ram_rd is valid
  // for the next edge.
  assign ram_q = mem[ram_addr];

  always #5 clk_sys = ~clk_sys;

  nvram_upload_server dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .cpu_busy(cpu_busy),
    .cpu_we(cpu_we), .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q),
    .vblank(vblank), .dirty(dirty), .save_req(save_req)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Issue a one-cycle read request; returns just after request edge T0.
  task automatic request(input logic [7:0] idx, input logic [24:0] a);
    ioctl_upload = 1'b1;
    ioctl_index  = idx;
    ioctl_addr   = a;
    ioctl_rd     = 1'b1;
    tick();
    ioctl_rd     = 1'b0;
  endtask

  task automatic vb_pulse();
    vblank = 1'b1;
    tick();
    if (save_req) save_seen++;
    vblank = 1'b0;
    tick();
    if (save_req) save_seen++;
  endtask

  task automatic we_pulse();
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ioctl_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h expected 00", ioctl_din); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b expected 0", ioctl_wait); end
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd got %b expected 0", ram_rd); end
    checks++; if (ram_addr !== 10'd0) begin errors++; $display("FAIL reset_ram_addr got %h expected 000", ram_addr); end
    checks++; if (dirty !== 1'b0 || save_req !== 1'b0) begin errors++; $display("FAIL reset_dirty_save got %b%b expected 00", dirty, save_req); end
    tick();
    reset_n = 1'b1;
    tick();
    $display("reset: din=%h wait=%b dirty=%b", ioctl_din, ioctl_wait, dirty);
  endtask

  // Uncontended read with cycle-by-cycle timing checks.
  task automatic test_read(input logic [24:0] a, input logic [7:0] exp_din);
    request(8'd4, a);
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL read_t0_wait got %b expected 0", ioctl_wait); end
    tick();
    checks++; if (ioctl_wait !== 1'b1 || ram_rd !== 1'b1) begin errors++; $display("FAIL read_t1 got wait=%b rd=%b expected 1 1", ioctl_wait, ram_rd); end
    checks++; if (ram_addr !== a[9:0]) begin errors++; $display("FAIL read_t1_addr got %h expected %h", ram_addr, a[9:0]); end
    tick();
    checks++; if (ioctl_wait !== 1'b1 || ram_rd !== 1'b0) begin errors++; $display("FAIL read_t2 got wait=%b rd=%b expected 1 0", ioctl_wait, ram_rd); end
    tick();
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL read_t3_wait got %b expected 0", ioctl_wait); end
    checks++; if (ioctl_din !== exp_din) begin errors++; $display("FAIL read_t3_din got %h expected %h", ioctl_din, exp_din); end
    $display("read addr=%h din=%h", a, ioctl_din);
  endtask

  // CPU holds the port for 4 cycles from T1; previous din was F3.
  task automatic test_contended();
    int rd_at = 0;
    int rd_cnt = 0;
    int wcnt = 0;
    request(8'd4, 25'h5);
    cpu_busy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 4) cpu_busy = 1'b0;
      if (ram_rd) begin rd_at = k; rd_cnt++; end
      if (ioctl_wait) wcnt++;
      if (k == 6) begin
        checks++; if (ioctl_din !== 8'hF3) begin errors++; $display("FAIL cont_hold_din got %h expected f3", ioctl_din); end
      end
      if (k == 7) begin
        checks++; if (ioctl_din !== 8'hFA) begin errors++; $display("FAIL cont_din got %h expected fa", ioctl_din); end
      end
    end
    checks++; if (rd_at !== 5 || rd_cnt !== 1) begin errors++; $display("FAIL cont_ram_rd got at=%0d n=%0d expected at=5 n=1", rd_at, rd_cnt); end
    checks++; if (wcnt !== 6) begin errors++; $display("FAIL cont_wait_cycles got %0d expected 6", wcnt); end
    $display("contended: rd_at=%0d wait_cycles=%0d din=%h", rd_at, wcnt, ioctl_din);
  endtask

  task automatic test_out_of_range();
    int rd_cnt = 0;
    int wcnt = 0;
    request(8'd4, 25'h400);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (ram_rd) rd_cnt++;
      if (ioctl_wait) wcnt++;
      if (k == 1) begin
        checks++; if (ioctl_din !== 8'hFA) begin errors++; $display("FAIL oob_t1_din got %h expected fa", ioctl_din); end
      end
      if (k == 2) begin
        checks++; if (ioctl_din !== 8'hFF) begin errors++; $display("FAIL oob_t2_din got %h expected ff", ioctl_din); end
      end
    end
    checks++; if (rd_cnt !== 0 || wcnt !== 1) begin errors++; $display("FAIL oob_access got rd=%0d wait=%0d expected 0 1", rd_cnt, wcnt); end
    $display("out_of_range: wait_cycles=%0d din=%h", wcnt, ioctl_din);
  endtask

  task automatic test_wrong_index();
    int rd_cnt = 0;
    int wcnt = 0;
    request(8'd0, 25'h5);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (ram_rd) rd_cnt++;
      if (ioctl_wait) wcnt++;
    end
    checks++; if (rd_cnt !== 0 || wcnt !== 0) begin errors++; $display("FAIL idx0_ignored got rd=%0d wait=%0d expected 0 0", rd_cnt, wcnt); end
    checks++; if (ioctl_din !== 8'hFF) begin errors++; $display("FAIL idx0_din got %h expected ff", ioctl_din); end
    $display("wrong_index: wait_cycles=%0d din=%h", wcnt, ioctl_din);
  endtask

  task automatic test_save();
    ioctl_index = 8'd4;
    save_seen = 0;
    for (int i = 0; i < 3; i++) vb_pulse();
    checks++; if (dirty !== 1'b0 || save_seen !== 0) begin errors++; $display("FAIL clean_vblank got dirty=%b saves=%0d expected 0 0", dirty, save_seen); end
    we_pulse();
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL we_dirty got %b expected 1", dirty); end
    for (int i = 0; i < 119; i++) vb_pulse();
    checks++; if (save_seen !== 0) begin errors++; $display("FAIL save_early got %0d expected 0", save_seen); end
    vblank = 1'b1;
    tick();
    checks++; if (save_req !== 1'b1) begin errors++; $display("FAIL save_edge120 got %b expected 1", save_req); end
    if (save_req) save_seen++;
    vblank = 1'b0;
    tick();
    if (save_req) save_seen++;
    for (int i = 0; i < 10; i++) vb_pulse();
    checks++; if (save_seen !== 1) begin errors++; $display("FAIL save_once got %0d expected 1", save_seen); end
    $display("save: dirty=%b saves=%0d", dirty, save_seen);
    // Restart: write after edge 60 pushes the request out by 120 edges.
    save_seen = 0;
    we_pulse();
    for (int i = 0; i < 60; i++) vb_pulse();
    we_pulse();
    for (int i = 0; i < 119; i++) vb_pulse();
    checks++; if (save_seen !== 0) begin errors++; $display("FAIL restart_early got %0d expected 0", save_seen); end
    vb_pulse();
    checks++; if (save_seen !== 1) begin errors++; $display("FAIL restart_save got %0d expected 1", save_seen); end
    $display("save_restart: saves=%0d", save_seen);
  endtask

  task automatic test_upload_fall();
    ioctl_index  = 8'd4;
    ioctl_upload = 1'b1;
    tick();
    ioctl_upload = 1'b0;
    tick();
    checks++; if (dirty !== 1'b0) begin errors++; $display("FAIL fall_clear got %b expected 0", dirty); end
    // Advance the counter, then collide a write with the falling edge.
    we_pulse();
    save_seen = 0;
    for (int i = 0; i < 5; i++) vb_pulse();
    ioctl_upload = 1'b1;
    tick();
    ioctl_upload = 1'b0;
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    checks++; if (dirty !== 1'b1) begin errors++; $display("FAIL fall_we_dirty got %b expected 1", dirty); end
    for (int i = 0; i < 119; i++) vb_pulse();
    checks++; if (save_seen !== 0) begin errors++; $display("FAIL fall_we_cnt_early got %0d expected 0", save_seen); end
    vb_pulse();
    checks++; if (save_seen !== 1) begin errors++; $display("FAIL fall_we_cnt_save got %0d expected 1", save_seen); end
    $display("upload_fall: dirty=%b saves=%0d", dirty, save_seen);
  endtask

  task automatic test_reset_mid();
    int rd_cnt = 0;
    we_pulse();
    request(8'd4, 25'h5);
    cpu_busy = 1'b1;
    tick();
    checks++; if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL mid_arb_wait got %b expected 1", ioctl_wait); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ioctl_wait !== 1'b0 || ram_rd !== 1'b0) begin errors++; $display("FAIL mid_rst_port got wait=%b rd=%b expected 0 0", ioctl_wait, ram_rd); end
    checks++; if (dirty !== 1'b0 || ioctl_din !== 8'h00) begin errors++; $display("FAIL mid_rst_state got dirty=%b din=%h expected 0 00", dirty, ioctl_din); end
    tick();
    if (ram_rd) rd_cnt++;
    reset_n  = 1'b1;
    cpu_busy = 1'b0;
    tick();
    if (ram_rd) rd_cnt++;
    checks++; if (rd_cnt !== 0 || ioctl_wait !== 1'b0) begin errors++; $display("FAIL mid_no_inflight got rd=%0d wait=%b expected 0 0", rd_cnt, ioctl_wait); end
    $display("reset_mid: wait=%b dirty=%b din=%h", ioctl_wait, dirty, ioctl_din);
    test_read(25'h5, 8'hFA);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
    mem[5]    = 4'hA;
    mem[1023] = 4'h3;
    test_reset();
    test_read(25'h5, 8'hFA);
    test_read(25'h3FF, 8'hF3);
    test_contended();
    test_out_of_range();
    test_wrong_index();
    test_save();
    test_upload_fall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
